// File: rtl/margin_scan_pkg.sv
`default_nettype none
//==============================================================================
// Module : margin_scan_pkg
// Brief  : Shared state encoding, width helper and default widths for the
//          margin-scan sequencer.
// Rev    : 1.0  initial release
//==============================================================================
package margin_scan_pkg;

    // Sequencer state encoding
    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_scan  = 2'd1;
    localparam logic [1:0] c_st_drain = 2'd2;
    localparam logic [1:0] c_st_done  = 2'd3;

    // Bit width needed to hold 0..value-1, never narrower than one bit
    function automatic int clog2_min1(input int value);
        if (value <= 2) return 1;
        return $clog2(value);
    endfunction

    // Default geometry of the score memory
    localparam int DEF_N_SAMPLES  = 512;
    localparam int DEF_N_CLASSES  = 10;

    localparam int SAMPLE_W = clog2_min1(DEF_N_SAMPLES);
    localparam int CLASS_W  = clog2_min1(DEF_N_CLASSES);
    localparam int ADDR_W   = clog2_min1(DEF_N_SAMPLES * DEF_N_CLASSES);

endpackage
`default_nettype wire

// File: rtl/scan_tag_pipe.sv
`default_nettype none
//==============================================================================
// Module : scan_tag_pipe
// Brief  : Fixed-depth delay line with async reset and synchronous flush.
//          Carries read tags so they line up with memory read data.
// Rev    : 1.0  initial release
//==============================================================================
module scan_tag_pipe #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
        logic [WIDTH-1:0] r_q;
        if (gi == 0) begin : g_head
            // First stage captures the incoming tag, flush empties it
            always_ff @(posedge clk or posedge rst) begin
                if (rst)        r_q <= '0;
                else if (flush) r_q <= '0;
                else            r_q <= d;
            end
        end else begin : g_tail
            // Later stages shift the previous stage forward every cycle
            always_ff @(posedge clk or posedge rst) begin
                if (rst)        r_q <= '0;
                else if (flush) r_q <= '0;
                else            r_q <= g_stage[gi-1].r_q;
            end
        end
    end

    assign q = g_stage[DEPTH-1].r_q;

endmodule
`default_nettype wire

// File: rtl/margin_scan_ctrl.sv
`default_nettype none
//==============================================================================
// Module : margin_scan_ctrl
// Brief  : Walks every (sample, class) pair of the score memory in row-major
//          order, one read per ready cycle, and emits latency-aligned tags
//          plus busy/done status. Supports abort.
// Rev    : 1.0  initial release
//==============================================================================
module margin_scan_ctrl
    import margin_scan_pkg::*;
#(
    parameter int N_SAMPLES  = 512,
    parameter int N_CLASSES  = 10,
    parameter int RD_LATENCY = 2,
    localparam int c_sample_w = clog2_min1(N_SAMPLES),
    localparam int c_addr_w   = clog2_min1(N_SAMPLES * N_CLASSES)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  ready,
    output logic                  rd_en,
    output logic [c_addr_w-1:0]   rd_addr,
    output logic                  tag_valid,
    output logic [c_sample_w-1:0] tag_sample,
    output logic                  tag_first,
    output logic                  tag_last,
    output logic                  busy,
    output logic                  done
);

    localparam int c_class_w = clog2_min1(N_CLASSES);
    localparam int c_drain_w = clog2_min1(RD_LATENCY);
    localparam int c_tag_w   = c_sample_w + 3;

    logic [1:0]            r_state;
    logic [c_class_w-1:0]  r_cls;
    logic [c_sample_w-1:0] r_smp;
    logic [c_addr_w-1:0]   r_addr;
    logic [c_drain_w-1:0]  r_drain;

    logic                  w_rd_en;
    logic                  w_last_cls;
    logic                  w_last_smp;
    logic [c_tag_w-1:0]    w_tag_in;
    logic [c_tag_w-1:0]    w_tag_out;

    assign w_rd_en    = (r_state == c_st_scan) && ready;
    assign w_last_cls = (r_cls == c_class_w'(N_CLASSES - 1));
    assign w_last_smp = (r_smp == c_sample_w'(N_SAMPLES - 1));

    // Sequencer: scan counters advance only on an issued read; the address
    // is kept as its own running counter so no multiplier is needed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_idle;
            r_cls   <= '0;
            r_smp   <= '0;
            r_addr  <= '0;
            r_drain <= '0;
        end else if (abort) begin
            r_state <= c_st_idle;
            r_cls   <= '0;
            r_smp   <= '0;
            r_addr  <= '0;
            r_drain <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (start) r_state <= c_st_scan;
                end
                c_st_scan: begin
                    if (w_rd_en) begin
                        if (w_last_cls) begin
                            r_cls <= '0;
                            if (w_last_smp) begin
                                r_smp   <= '0;
                                r_addr  <= '0;
                                r_drain <= c_drain_w'(RD_LATENCY - 1);
                                r_state <= c_st_drain;
                            end else begin
                                r_smp  <= r_smp + c_sample_w'(1);
                                r_addr <= r_addr + c_addr_w'(1);
                            end
                        end else begin
                            r_cls  <= r_cls + c_class_w'(1);
                            r_addr <= r_addr + c_addr_w'(1);
                        end
                    end
                end
                c_st_drain: begin
                    if (r_drain == '0) r_state <= c_st_done;
                    else               r_drain <= r_drain - c_drain_w'(1);
                end
                c_st_done: begin
                    r_state <= c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    // Idle slots enter the pipe as all-zero so tag fields are quiet
    // whenever tag_valid is low
    assign w_tag_in = w_rd_en ? {1'b1, r_smp, (r_cls == '0), w_last_cls} : '0;

    scan_tag_pipe #(
        .WIDTH (c_tag_w),
        .DEPTH (RD_LATENCY)
    ) u_tag_pipe (
        .clk   (clk),
        .rst   (rst),
        .flush (abort),
        .d     (w_tag_in),
        .q     (w_tag_out)
    );

    assign rd_en   = w_rd_en;
    assign rd_addr = r_addr;
    assign busy    = (r_state != c_st_idle);
    assign done    = (r_state == c_st_done);
    assign {tag_valid, tag_sample, tag_first, tag_last} = w_tag_out;

endmodule
`default_nettype wire

// File: tb/tb_margin_scan_ctrl.sv
`default_nettype none
//==============================================================================
// Module : tb_margin_scan_ctrl
// Brief  : Scoreboard bench for margin_scan_ctrl; two instances share the
//          stimulus, one with read latency 2 and one with read latency 1.
// Rev    : 1.0  initial release
//==============================================================================
module tb_margin_scan_ctrl;

    localparam int c_ns       = 4;
    localparam int c_nc       = 3;
    localparam int c_reads    = c_ns * c_nc;
    localparam int c_addr_w   = $clog2(c_reads);
    localparam int c_sample_w = $clog2(c_ns);

    logic clk   = 1'b0;
    logic rst   = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic ready = 1'b0;

    logic                  rd_en_a      [2];
    logic [c_addr_w-1:0]   rd_addr_a    [2];
    logic                  tag_valid_a  [2];
    logic [c_sample_w-1:0] tag_sample_a [2];
    logic                  tag_first_a  [2];
    logic                  tag_last_a   [2];
    logic                  busy_a       [2];
    logic                  done_a       [2];

    for (genvar k = 0; k < 2; k++) begin : g_dut
        margin_scan_ctrl #(
            .N_SAMPLES  (c_ns),
            .N_CLASSES  (c_nc),
            .RD_LATENCY ((k == 0) ? 2 : 1)
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .start      (start),
            .abort      (abort),
            .ready      (ready),
            .rd_en      (rd_en_a[k]),
            .rd_addr    (rd_addr_a[k]),
            .tag_valid  (tag_valid_a[k]),
            .tag_sample (tag_sample_a[k]),
            .tag_first  (tag_first_a[k]),
            .tag_last   (tag_last_a[k]),
            .busy       (busy_a[k]),
            .done       (done_a[k])
        );
    end

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    // Reference model state per instance
    int exp_addr [2][$];   // addresses still to be read in this scan
    int m_tag    [2][$];   // addresses read, tag not yet delivered
    int rd_cyc   [2][$];   // cycles in which those reads were issued
    bit m_busy   [2];
    int m_due    [2];      // cycle of the expected done pulse, -1 if none

    function automatic int lat(input int k);
        return (k == 0) ? 2 : 1;
    endfunction

    task automatic check(input string name, input int k, input longint act, input longint want);
        n_total++;
        if (act == want) n_pass++;
        else $display("FAIL %s dut%0d cycle %0d: got %0d, expected %0d", name, k, cyc, act, want);
    endtask

    task automatic clear_model(input int k);
        exp_addr[k].delete();
        m_tag[k].delete();
        rd_cyc[k].delete();
        m_busy[k] = 1'b0;
        m_due[k]  = -1;
    endtask

    // Monitor: compares every cycle against the model, sampled mid-cycle
    initial begin
        for (int k = 0; k < 2; k++) m_due[k] = -1;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                for (int k = 0; k < 2; k++) clear_model(k);
                continue;
            end
            for (int k = 0; k < 2; k++) begin
                bit was_busy;
                bit exp_rd;
                bit exp_tv;
                int a;
                was_busy = m_busy[k];
                exp_rd   = m_busy[k] && (exp_addr[k].size() > 0) && ready;
                check("rd_en", k, rd_en_a[k], exp_rd);
                if (rd_en_a[k] && exp_addr[k].size() > 0) begin
                    a = exp_addr[k].pop_front();
                    check("rd_addr", k, rd_addr_a[k], a);
                    m_tag[k].push_back(a);
                    rd_cyc[k].push_back(cyc);
                    if (exp_addr[k].size() == 0) m_due[k] = cyc + lat(k) + 1;
                end
                exp_tv = (rd_cyc[k].size() > 0) && (rd_cyc[k][0] == cyc - lat(k));
                check("tag_valid", k, tag_valid_a[k], exp_tv);
                if (exp_tv) begin
                    void'(rd_cyc[k].pop_front());
                    a = m_tag[k].pop_front();
                    check("tag_sample", k, tag_sample_a[k], a / c_nc);
                    check("tag_first",  k, tag_first_a[k],  (a % c_nc) == 0);
                    check("tag_last",   k, tag_last_a[k],   (a % c_nc) == c_nc - 1);
                end
                check("done", k, done_a[k], cyc == m_due[k]);
                check("busy", k, busy_a[k], m_busy[k]);
                if (cyc == m_due[k]) begin
                    m_busy[k] = 1'b0;
                    m_due[k]  = -1;
                end
                if (abort) clear_model(k);
                else if (start && !was_busy) m_busy[k] = 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_start();
        for (int k = 0; k < 2; k++)
            for (int a = 0; a < c_reads; a++) exp_addr[k].push_back(a);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300; i++) begin
            if (!busy_a[0] && !busy_a[1]) return;
            tick();
        end
        n_total++;
        $display("FAIL wait_idle: busy still high after 300 cycles");
    endtask

    task automatic wait_addr(input int a);
        for (int i = 0; i < 100; i++) begin
            if (rd_en_a[0] && rd_addr_a[0] == c_addr_w'(a)) return;
            tick();
        end
        n_total++;
        $display("FAIL wait_addr: read of address %0d never issued", a);
    endtask

    task automatic check_zero(input string tag);
        for (int k = 0; k < 2; k++) begin
            check({tag, "_rd_en"},      k, rd_en_a[k],      0);
            check({tag, "_rd_addr"},    k, rd_addr_a[k],    0);
            check({tag, "_tag_valid"},  k, tag_valid_a[k],  0);
            check({tag, "_tag_sample"}, k, tag_sample_a[k], 0);
            check({tag, "_tag_first"},  k, tag_first_a[k],  0);
            check({tag, "_tag_last"},   k, tag_last_a[k],   0);
            check({tag, "_busy"},       k, busy_a[k],       0);
            check({tag, "_done"},       k, done_a[k],       0);
        end
    endtask

    // Stimulus
    initial begin
        int abort_at;
        #1 rst = 1'b1;
        #2 check_zero("reset");
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Plain scan with downstream always ready
        ready = 1'b1;
        issue_start();
        wait_idle();
        tick();

        // Stray start in the middle of a scan
        issue_start();
        repeat (4) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_idle();
        tick();

        // Three-cycle stall right after address 4 is read
        issue_start();
        wait_addr(4);
        tick();
        ready = 1'b0;
        repeat (3) tick();
        ready = 1'b1;
        wait_idle();
        tick();

        // Abort while address 7 is being read, then start+abort together
        issue_start();
        wait_addr(7);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        tick();
        issue_start();
        wait_idle();
        tick();

        // Random backpressure, one scan also aborted at a random point
        for (int s = 0; s < 6; s++) begin
            abort_at = $urandom_range(0, 9);
            issue_start();
            for (int i = 0; i < 400 && (busy_a[0] || busy_a[1]); i++) begin
                ready = ($urandom_range(0, 3) != 0);
                abort = (s == 4) && (i == abort_at);
                tick();
            end
            abort = 1'b0;
            ready = 1'b1;
            wait_idle();
            tick();
        end

        // Asynchronous reset landing in the drain phase
        ready = 1'b1;
        issue_start();
        wait_addr(c_reads - 1);
        tick();
        #2;
        check("pre_rst_busy", 0, busy_a[0], 1);
        check("pre_rst_busy", 1, busy_a[1], 1);
        check("pre_rst_tag_valid", 0, tag_valid_a[0], 1);
        rst = 1'b1;
        #1 check_zero("async_rst");
        tick();
        rst = 1'b0;
        tick();

        // Recovery scan after reset
        issue_start();
        wait_idle();
        repeat (3) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Hard stop in case the bench itself stalls
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
